// File: rtl/pipe_reg_chain.sv
// pipe_reg_chain: elastic valid/ready register chain with bubble collapse, flush and occupancy count
module pipe_reg_chain #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   count
);
   localparam int CW = $clog2(DEPTH+1);
   logic [DEPTH-1:0] v, r, vu;
   logic [WIDTH-1:0] d  [DEPTH];
   logic [WIDTH-1:0] du [DEPTH];
   // a stage may capture unless it and every stage downstream are full and the output stalls
   for (genvar i = 0; i < DEPTH; i++) begin : g_r
      assign r[i] = out_ready | ~&v[DEPTH-1:i];
   end
   always_comb begin
      vu[0] = in_valid;
      du[0] = in_data;
      for (int i = 1; i < DEPTH; i++) begin
         vu[i] = v[i-1];
         du[i] = d[i-1];
      end
   end
   assign in_ready  = r[0] & ~flush;
   assign out_valid = v[DEPTH-1] & ~flush;
   assign out_data  = d[DEPTH-1];
   assign count     = CW'($countones(v));
   always_ff @(posedge clk) begin
      if (!reset) begin
         v <= '0;
         for (int i = 0; i < DEPTH; i++) d[i] <= RESET_VAL;
      end else if (flush) begin
         v <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++)
            if (r[i]) begin
               v[i] <= vu[i];
               d[i] <= du[i];
            end
      end
   end
endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb_pipe_reg_chain: directed and random stimulus against a FIFO-with-latency scoreboard model
module tb_pipe_reg_chain;
   localparam int W = 8;
   localparam int D = 3;
   localparam logic [W-1:0] RV = 8'hA5;
   logic clk = 0, reset = 0, flush = 0, in_valid = 0, out_ready = 0;
   logic in_ready, out_valid;
   logic [W-1:0] in_data = '0, out_data;
   logic [1:0] count;
   typedef struct {logic [W-1:0] d; int t;} item_t;
   item_t q[$];
   int cyc = 0, n_cmp = 0, n_err = 0;
   bit started = 0, ov_e, ir_e, last_hs;
   always #5 clk = ~clk;
   pipe_reg_chain #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .count(count)
   );
   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at cycle %0d: got %0h, expected %0h", n, cyc, act, exp);
      end
   endtask
   always @(posedge clk) cyc <= cyc + 1;
   // model: a word is visible at the output once DEPTH edges have passed since its handshake cycle
   always @(negedge clk) begin
      if (!reset) begin
         q.delete();
         started = 1;
      end else if (started) begin
         ov_e = q.size() > 0 && cyc >= q[0].t + D;
         ir_e = q.size() < D || out_ready;
         chk("count", count, q.size());
         chk("out_valid", out_valid, ov_e && !flush);
         chk("in_ready", in_ready, ir_e && !flush);
         if (flush) q.delete();
         else begin
            if (ov_e) chk("out_data", out_data, q[0].d);
            if (ov_e && out_ready) void'(q.pop_front());
            if (in_valid && ir_e) q.push_back('{in_data, cyc});
         end
      end
   end
   task automatic drive(bit iv, logic [W-1:0] dt, bit ordy, bit fl = 0, bit rs = 1);
      in_valid = iv;
      in_data = dt;
      out_ready = ordy;
      flush = fl;
      reset = rs;
      @(negedge clk);
      last_hs = in_valid && in_ready && reset;
      @(posedge clk);
      #1;
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      reset = 1;
      @(negedge clk);
      chk("reset_out_data", out_data, RV);
      @(posedge clk);
      #1;
      for (int i = 1; i <= 8; i++) drive(1, W'(i), 1);
      repeat (4) drive(0, 0, 1);
      drive(1, 8'h11, 0);
      drive(0, 0, 0);
      drive(1, 8'h22, 0);
      drive(1, 8'h33, 0);
      drive(1, 8'h44, 0);
      drive(1, 8'h44, 1);
      repeat (5) drive(0, 0, 1);
      drive(1, 8'h55, 0);
      drive(1, 8'h66, 0);
      drive(1, 8'h77, 0, 1);
      repeat (5) drive(0, 0, 1);
      drive(1, 8'h81, 0);
      drive(1, 8'h82, 0);
      drive(0, 0, 1, 0, 0);
      chk("midreset_out_data", out_data, RV);
      drive(1, 8'h99, 1);
      repeat (5) drive(0, 0, 1);
      for (int k = 0; k < 3000; k++) begin
         if (!in_valid || last_hs) drive($urandom % 4 != 0, W'($urandom), $urandom % 3 != 0,
                                         $urandom % 40 == 0, $urandom % 150 != 0);
         else drive(1, in_data, $urandom % 3 != 0, $urandom % 40 == 0, $urandom % 150 != 0);
      end
      repeat (6) drive(0, 0, 1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
   initial begin
      #500000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "timeout");
   end
endmodule
